// File: rtl/fetch_controller.sv
// RV32I fetch sequencer: owns the fetch PC, runs a single-outstanding
// imem handshake and holds each fetched word until decode takes it.
module fetch_controller #(
  parameter int ADDRESS = 32,
  parameter int INSTRUCTION = 32,
  parameter logic [ADDRESS-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [ADDRESS-1:0]     imem_addr,
  input  logic                   imem_ready,
  input  logic                   imem_rvalid,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  input  logic                   stall_in,
  input  logic                   redirect_valid,
  input  logic [ADDRESS-1:0]     redirect_addr,
  output logic                   instr_valid,
  output logic [INSTRUCTION-1:0] instruction,
  output logic [ADDRESS-1:0]     pc_addr_out
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DROP
  } state_t;

  state_t state;
  logic [ADDRESS-1:0] fetch_pc;
  logic in_flight;
  logic unused_lsb;

  assign imem_req = (state == REQ);
  assign imem_addr = fetch_pc;
  assign unused_lsb = ^redirect_addr[1:0];

  // A redirect must wait out a response that is still owed to us.
  always_comb begin
    in_flight = 1'b0;
    unique case (state)
      REQ:     in_flight = imem_ready;
      WAIT:    in_flight = !imem_rvalid;
      DROP:    in_flight = !imem_rvalid;
      default: in_flight = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= '0;
      pc_addr_out <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_addr[ADDRESS-1:2], 2'b00};
      instr_valid <= 1'b0;
      state <= in_flight ? DROP : REQ;
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            instruction <= imem_rdata;
            pc_addr_out <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_pc <= fetch_pc + ADDRESS'(4);
            state <= OUT;
          end
        end
        OUT: begin
          if (!stall_in) begin
            instr_valid <= 1'b0;
            state <= REQ;
          end
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Randomized scoreboard bench for fetch_controller with an
// imem responder and a program-order fetch model.
module tb_fetch_controller;

  localparam logic [31:0] RPC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  logic imem_req;
  logic [31:0] imem_addr;
  logic imem_ready;
  logic imem_rvalid;
  logic [31:0] imem_rdata;
  logic stall_in;
  logic redirect_valid;
  logic [31:0] redirect_addr;
  logic instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_addr_out;

  always #5 clk = ~clk;

  fetch_controller #(
    .ADDRESS(32),
    .INSTRUCTION(32),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .stall_in(stall_in),
    .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .pc_addr_out(pc_addr_out)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } item_t;

  int total = 0;
  int bad = 0;
  item_t sb[$];
  int rise_cyc[$];
  int cyc = 0;

  // memory/program model
  logic [31:0] exp_pc;
  logic [31:0] paddr;
  bit pend;
  bit stale;
  int dly;
  bit prev_iv, prev_stall, prev_redir, prev_rst;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode 0 random, 1 fast, 2 fast+stall, 3 quiet random memory
  task automatic step(input bit r, input int mode);
    bit fast;
    fast = (mode == 1 || mode == 2);
    if (prev_iv && !prev_redir && !prev_rst) begin
      if (prev_stall) chk("hold_valid", {31'b0, instr_valid}, 1);
      else chk("consume", {31'b0, instr_valid}, 0);
    end
    if (instr_valid) chk("one_outstanding", {31'b0, imem_req}, 0);
    rst = r;
    redirect_valid = (mode == 0) && ($urandom_range(99) < 7);
    case ($urandom_range(3))
      0: redirect_addr = 32'hFFFF_FFFC;
      1: redirect_addr = 32'h0000_0203;
      default: redirect_addr = $urandom;
    endcase
    stall_in = (mode == 2) || (mode == 0 && $urandom_range(99) < 35);
    imem_rvalid = pend && (dly == 0);
    imem_rdata = imem_rvalid ? word(paddr) : $urandom;
    imem_ready = !r && !pend && (fast || $urandom_range(99) < 70);
    if (r) begin
      exp_pc = RPC;
      if (pend) stale = 1;
      if (imem_rvalid) pend = 0;
    end else begin
      if (imem_rvalid) begin
        pend = 0;
        if (!stale && !redirect_valid) begin
          sb.push_back(item_t'({paddr, word(paddr)}));
          exp_pc = paddr + 32'd4;
        end
      end
      if (imem_req && imem_ready) begin
        chk("req_addr", imem_addr, exp_pc);
        pend = 1;
        paddr = exp_pc;
        dly = fast ? 0 : int'($urandom_range(3));
        stale = 0;
      end else if (pend) begin
        dly--;
      end
      if (redirect_valid) begin
        stale = 1;
        exp_pc = {redirect_addr[31:2], 2'b00};
      end
    end
    prev_iv = instr_valid;
    prev_stall = stall_in;
    prev_redir = redirect_valid;
    prev_rst = r;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, {31'b0, imem_req}, 0);
    chk({tag, "_addr"}, imem_addr, RPC);
    chk({tag, "_valid"}, {31'b0, instr_valid}, 0);
    chk({tag, "_instr"}, instruction, 32'h0);
    chk({tag, "_pc"}, pc_addr_out, RPC);
  endtask

  // monitor: pops one expectation per newly presented instruction
  initial begin
    item_t cur;
    bit have;
    bit last;
    have = 0;
    last = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (instr_valid && !last) begin
        rise_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          total++;
          bad++;
          have = 0;
          $display("FAIL unexpected_instr: got pc %h expected none",
                   pc_addr_out);
        end else begin
          cur = sb.pop_front();
          have = 1;
        end
      end
      if (instr_valid && have) begin
        chk("pc_addr_out", pc_addr_out, cur.pc);
        chk("instruction", instruction, cur.ins);
      end
      last = instr_valid;
    end
  end

  initial begin
    rst = 1;
    imem_ready = 0;
    imem_rvalid = 0;
    imem_rdata = 0;
    stall_in = 0;
    redirect_valid = 0;
    redirect_addr = 0;
    pend = 0;
    stale = 0;
    dly = 0;
    paddr = 0;
    exp_pc = RPC;
    prev_iv = 0;
    prev_stall = 0;
    prev_redir = 0;
    prev_rst = 1;
    repeat (3) @(negedge clk);
    chk_reset("reset");

    step(0, 1);
    chk("first_req", {31'b0, imem_req}, 1);
    repeat (11) step(0, 1);
    chk("fast_count", 32'(rise_cyc.size()), 4);
    for (int i = 1; i < 4 && i < rise_cyc.size(); i++)
      chk("fast_gap", 32'(rise_cyc[i] - rise_cyc[i-1]), 3);

    for (int i = 0; i < 10 && !instr_valid; i++) step(0, 1);
    chk("stall_start", {31'b0, instr_valid}, 1);
    repeat (5) step(0, 2);
    repeat (6) step(0, 1);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        for (int k = 0; k < 60 && !pend; k++) step(0, 3);
        if (pend) dly = 1;
        step(1, 3);
        step(1, 3);
        chk_reset("midreset");
      end
      step(0, 0);
    end

    repeat (40) step(0, 3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
